// File: rtl/biriscv_trace_buffer_pkg.sv
// Shared encodings and entry layout for the retire-trace capture buffer.
package biriscv_trace_buffer_pkg;

    localparam int TRACE_SEQ_W   = 16;
    localparam int TRACE_ENTRY_W = 80;

    typedef enum logic [1:0] {
        TRACE_STATE_IDLE   = 2'd0,
        TRACE_STATE_ARMED  = 2'd1,
        TRACE_STATE_POST   = 2'd2,
        TRACE_STATE_FROZEN = 2'd3
    } trace_state_t;

    typedef struct packed {
        logic [31:0]            pc;
        logic [31:0]            opcode;
        logic [TRACE_SEQ_W-1:0] seq;
    } trace_entry_t;

endpackage

// File: rtl/biriscv_trace_ram.sv
// Trace entry store: one write port per retire lane, asynchronous read for show-ahead.
module biriscv_trace_ram
    import biriscv_trace_buffer_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 64
) (
    input  logic                                   clk_i,
    input  logic [LANES-1:0]                       wr_en_i,
    input  logic [LANES-1:0][$clog2(DEPTH)-1:0]    wr_addr_i,
    input  trace_entry_t [LANES-1:0]               wr_data_i,
    input  logic [$clog2(DEPTH)-1:0]               rd_addr_i,
    output trace_entry_t                           rd_data_o
);

    trace_entry_t mem [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int l = 0; l < LANES; l++) begin
            if (wr_en_i[l]) begin
                mem[wr_addr_i[l]] <= wr_data_i[l];
            end
        end
    end

    assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/biriscv_trace_buffer.sv
// Retire-trace capture buffer: streaming FIFO or circular capture frozen by a PC trigger.
module biriscv_trace_buffer
    import biriscv_trace_buffer_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [LANES-1:0]           valid_i,
    input  logic [32*LANES-1:0]        pc_i,
    input  logic [32*LANES-1:0]        opcode_i,
    input  logic                       arm_i,
    input  logic                       mode_i,
    input  logic [31:0]                trig_pc_i,
    input  logic                       rd_ready_i,
    output logic                       rd_valid_o,
    output logic [31:0]                rd_pc_o,
    output logic [31:0]                rd_opcode_o,
    output logic [15:0]                rd_seq_o,
    output logic [1:0]                 state_o,
    output logic                       overflow_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_EXT = (CW+1)'(DEPTH);
    localparam logic MODE_STREAM = 1'b0;

    trace_state_t             state_q, state_d;
    logic                     mode_q, mode_d;
    logic [AW-1:0]            head_q, head_d;
    logic [AW-1:0]            tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d;
    logic [TRACE_SEQ_W-1:0]   seq_q, seq_d;
    logic                     overflow_q, overflow_d;
    logic [CW-1:0]            remaining_q, remaining_d;

    logic [31:0]              lane_pc [LANES];
    logic [31:0]              lane_op [LANES];

    logic [LANES-1:0]         wr_en;
    logic [LANES-1:0][AW-1:0] wr_addr;
    trace_entry_t [LANES-1:0] wr_data;
    trace_entry_t             rd_entry;

    logic                     rd_valid, pop, capture, in_post, drop;
    logic [CW-1:0]            free, n_valid, n_wr, rem;
    logic [CW:0]              cnt_sum;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_pc[gi] = pc_i[32*gi +: 32];
            assign lane_op[gi] = opcode_i[32*gi +: 32];
        end
    endgenerate

    // Readout is only exposed while streaming or after the capture has frozen.
    assign rd_valid = (count_q != '0) &&
                      (((state_q == TRACE_STATE_ARMED) && (mode_q == MODE_STREAM)) ||
                       (state_q == TRACE_STATE_FROZEN));

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        seq_d       = seq_q;
        overflow_d  = overflow_q;
        remaining_d = remaining_q;
        wr_en       = '0;
        wr_addr     = '0;
        wr_data     = '0;
        n_valid     = '0;
        n_wr        = '0;
        drop        = 1'b0;
        in_post     = (state_q == TRACE_STATE_POST);
        rem         = remaining_q;
        capture     = (state_q == TRACE_STATE_ARMED) || (state_q == TRACE_STATE_POST);
        pop         = rd_valid & rd_ready_i;
        free        = CW'(DEPTH) - count_q + CW'(pop);

        if (capture) begin
            for (int l = 0; l < LANES; l++) begin
                if (valid_i[l]) begin
                    wr_addr[l]        = tail_q + AW'(n_wr);
                    wr_data[l].pc     = lane_pc[l];
                    wr_data[l].opcode = lane_op[l];
                    wr_data[l].seq    = seq_q + TRACE_SEQ_W'(n_valid);
                    if (mode_q == MODE_STREAM) begin
                        if (n_wr < free) begin
                            wr_en[l] = 1'b1;
                            n_wr     = n_wr + CW'(1);
                        end else begin
                            drop = 1'b1;
                        end
                    end else begin
                        if (!in_post && (lane_pc[l] == trig_pc_i)) begin
                            in_post = 1'b1;
                            rem     = CW'(POST_TRIG);
                        end
                        if (!in_post) begin
                            wr_en[l] = 1'b1;
                            n_wr     = n_wr + CW'(1);
                        end else if (rem != '0) begin
                            wr_en[l] = 1'b1;
                            n_wr     = n_wr + CW'(1);
                            rem      = rem - CW'(1);
                        end
                    end
                    n_valid = n_valid + CW'(1);
                end
            end
        end

        // Circular capture past full drops the oldest entries by advancing the head.
        cnt_sum = {1'b0, count_q} - (CW+1)'(pop) + {1'b0, n_wr};
        head_d  = head_q + AW'(pop);
        if (cnt_sum > DEPTH_EXT) begin
            head_d  = head_d + AW'(cnt_sum - DEPTH_EXT);
            count_d = CW'(DEPTH);
        end else begin
            count_d = cnt_sum[CW-1:0];
        end
        tail_d = tail_q + AW'(n_wr);

        if (capture) begin
            seq_d      = seq_q + TRACE_SEQ_W'(n_valid);
            overflow_d = overflow_q | drop;
            if (in_post) begin
                remaining_d = rem;
                state_d     = (rem == '0) ? TRACE_STATE_FROZEN : TRACE_STATE_POST;
            end
        end

        if ((state_q == TRACE_STATE_FROZEN) && (count_d == '0)) begin
            state_d = TRACE_STATE_IDLE;
        end

        if (arm_i) begin
            state_d     = TRACE_STATE_ARMED;
            mode_d      = mode_i;
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            seq_d       = '0;
            overflow_d  = 1'b0;
            remaining_d = '0;
            wr_en       = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= TRACE_STATE_IDLE;
            mode_q      <= MODE_STREAM;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            seq_q       <= '0;
            overflow_q  <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            seq_q       <= seq_d;
            overflow_q  <= overflow_d;
            remaining_q <= remaining_d;
        end
    end

    biriscv_trace_ram #(
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i     (clk_i),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (head_q),
        .rd_data_o (rd_entry)
    );

    assign rd_valid_o  = rd_valid;
    assign rd_pc_o     = rd_valid ? rd_entry.pc     : '0;
    assign rd_opcode_o = rd_valid ? rd_entry.opcode : '0;
    assign rd_seq_o    = rd_valid ? rd_entry.seq    : '0;
    assign state_o     = state_q;
    assign overflow_o  = overflow_q;
    assign count_o     = count_q;

endmodule
